// File: rtl/golden_nonce_uart_tx.sv
// Golden-nonce reporter: buffers nonce strobes in a small FIFO and sends each as 8N1 UART bytes, LSB byte first.
// Define NONCE_CHECKSUM_EN to append a fifth byte holding the XOR of the four nonce bytes.
`default_nettype none

module golden_nonce_uart_tx #(
  parameter int SPEED_MHZ  = 50,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        hash_clk,
  input  logic        reset,
  input  logic [31:0] golden_nonce_in,
  input  logic        golden_nonce_valid,
  output logic        uart_tx,
  output logic        busy,
  output logic        overflow
);

  localparam int DIV    = (SPEED_MHZ * 1000000) / BAUD_RATE;
  localparam int BAUD_W = $clog2(DIV + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
`ifdef NONCE_CHECKSUM_EN
  localparam int NUM_BYTES = 5;
`else
  localparam int NUM_BYTES = 4;
`endif
  localparam int SR_W = 8 * NUM_BYTES;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]        LAST_BYTE = 3'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              fifo_full;
  logic              fifo_pop;
  logic              fifo_wr;
  logic              fifo_drop;

  state_t            state_reg;
  logic [BAUD_W-1:0] baud_cnt_reg;
  logic              baud_last;
  logic [2:0]        bit_idx_reg;
  logic [2:0]        byte_idx_reg;
  logic [SR_W-1:0]   shift_reg;
  logic [31:0]       head_word;
  logic [SR_W-1:0]   load_word;
  logic              frame_done;
  logic              idle_next;

  logic              uart_tx_reg;
  logic              busy_reg;
  logic              overflow_reg;

  // A full FIFO still accepts a write in the cycle the FSM pops the head.
  always_comb begin
    fifo_full  = (count_reg == DEPTH_C);
    fifo_pop   = (state_reg == ST_LOAD);
    fifo_wr    = golden_nonce_valid && (!fifo_full || fifo_pop);
    fifo_drop  = golden_nonce_valid && fifo_full && !fifo_pop;
    count_next = count_reg + CNT_W'(fifo_wr) - CNT_W'(fifo_pop);
    baud_last  = (baud_cnt_reg == BAUD_LAST);
    frame_done = (state_reg == ST_STOP) && baud_last && (byte_idx_reg == LAST_BYTE);
    idle_next  = ((state_reg == ST_IDLE) && (count_reg == '0)) || frame_done;
  end

  always_ff @(posedge hash_clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr_reg] <= golden_nonce_in;
    end
  end

  assign head_word = fifo_mem[rd_ptr_reg];

`ifdef NONCE_CHECKSUM_EN
  logic [7:0] head_bytes [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_head_bytes
    assign head_bytes[gi] = head_word[8*gi +: 8];
  end
  assign load_word = {head_bytes[0] ^ head_bytes[1] ^ head_bytes[2] ^ head_bytes[3], head_word};
`else
  assign load_word = head_word;
`endif

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  // Serialiser: the data shift register moves one bit per bit period, so the
  // next byte is already in the low bits when its start bit begins.
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      byte_idx_reg <= '0;
      shift_reg    <= '0;
      uart_tx_reg  <= 1'b1;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      busy_reg <= (count_next != '0) || !idle_next;
      if (fifo_drop) begin
        overflow_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          uart_tx_reg  <= 1'b1;
          baud_cnt_reg <= '0;
          if (count_reg != '0) begin
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          shift_reg    <= load_word;
          byte_idx_reg <= '0;
          baud_cnt_reg <= '0;
          uart_tx_reg  <= 1'b0;
          state_reg    <= ST_START;
        end
        ST_START: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            uart_tx_reg  <= shift_reg[0];
            state_reg    <= ST_DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            shift_reg    <= shift_reg >> 1;
            if (bit_idx_reg == 3'd7) begin
              uart_tx_reg <= 1'b1;
              state_reg   <= ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              uart_tx_reg <= shift_reg[1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            if (byte_idx_reg == LAST_BYTE) begin
              state_reg <= ST_IDLE;
            end else begin
              byte_idx_reg <= byte_idx_reg + 3'd1;
              uart_tx_reg  <= 1'b0;
              state_reg    <= ST_START;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        default: begin
          uart_tx_reg <= 1'b1;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign uart_tx  = uart_tx_reg;
  assign busy     = busy_reg;
  assign overflow = overflow_reg;

endmodule

`default_nettype wire

// File: tb/tb_golden_nonce_uart_tx.sv
// Bench for golden_nonce_uart_tx at DIV=10: a line decoder rebuilds bytes and start-bit times,
// compared with a byte-stream model built from the accepted nonces.
module tb_golden_nonce_uart_tx;

  localparam int SPEED_MHZ  = 1;
  localparam int BAUD_RATE  = 100000;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV        = 10;
`ifdef NONCE_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int FRAME     = 10 * DIV;
  localparam int NONCE_CYC = NB * FRAME;

  logic        hash_clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] golden_nonce_in = '0;
  logic        golden_nonce_valid = 1'b0;
  logic        uart_tx;
  logic        busy;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  golden_nonce_uart_tx #(
    .SPEED_MHZ (SPEED_MHZ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .hash_clk          (hash_clk),
    .reset             (reset),
    .golden_nonce_in   (golden_nonce_in),
    .golden_nonce_valid(golden_nonce_valid),
    .uart_tx           (uart_tx),
    .busy              (busy),
    .overflow          (overflow)
  );

  always #5 hash_clk = ~hash_clk;
  always @(posedge hash_clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, expected finish before cycle 90000");
    $fatal(1, "watchdog expired");
  end

  // Line decoder: every cycle of every bit must hold one level; start low, stop high.
  logic [7:0] bytes_q[$];
  int         fall_q[$];
  logic [7:0] exp_q[$];
  int         mon_pos = -1;
  int         mon_bitn;
  logic [7:0] mon_byte;
  logic       mon_bit;
  int         line_err = 0;

  always @(negedge hash_clk) begin
    if (reset) begin
      mon_pos = -1;
    end else begin
      if (mon_pos < 0) begin
        if (uart_tx === 1'b0) begin
          mon_pos = 0;
          fall_q.push_back(cyc);
        end
      end else begin
        mon_pos = mon_pos + 1;
      end
      if (mon_pos >= 0) begin
        mon_bitn = mon_pos / DIV;
        if (mon_bitn == 0) begin
          if (uart_tx !== 1'b0) line_err = line_err + 1;
        end else if (mon_bitn <= 8) begin
          if (mon_pos % DIV == 0) begin
            mon_bit = uart_tx;
            mon_byte[mon_bitn-1] = uart_tx;
          end else if (uart_tx !== mon_bit) begin
            line_err = line_err + 1;
          end
        end else if (uart_tx !== 1'b1) begin
          line_err = line_err + 1;
        end
        if (mon_pos == FRAME - 1) begin
          bytes_q.push_back(mon_byte);
          mon_pos = -1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a nonce goes out as its four little-endian bytes (plus XOR byte when enabled).
  task automatic model_push(input logic [31:0] v);
    logic [7:0] ck;
    ck = 8'h00;
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back(v[8*j +: 8]);
      ck = ck ^ v[8*j +: 8];
    end
`ifdef NONCE_CHECKSUM_EN
    exp_q.push_back(ck);
`endif
  endtask

  task automatic clear_q();
    bytes_q.delete();
    fall_q.delete();
    exp_q.delete();
  endtask

  task automatic strobe(input logic [31:0] v, output int n);
    @(negedge hash_clk);
    golden_nonce_in    = v;
    golden_nonce_valid = 1'b1;
    n = cyc + 1;
  endtask

  task automatic release_v();
    @(negedge hash_clk);
    golden_nonce_valid = 1'b0;
    golden_nonce_in    = '0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge hash_clk);
  endtask

  // Nonces queued together leave back to back with a 2-cycle gap between them.
  task automatic check_stream(input int t0);
    int budget;
    int texp;
    budget = 0;
    while (bytes_q.size() < exp_q.size() && budget < 30000) begin
      @(negedge hash_clk);
      budget++;
    end
    chk("byte_count", bytes_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < bytes_q.size(); k++) begin
      chk($sformatf("byte%0d", k), bytes_q[k], exp_q[k]);
      texp = t0 + (k / NB) * (NONCE_CYC + 2) + (k % NB) * FRAME;
      if (k < fall_q.size()) chk($sformatf("start_time%0d", k), fall_q[k], texp);
    end
    chk("line_err", line_err, 0);
    repeat (3) @(negedge hash_clk);
    chk("busy_idle", busy, 1'b0);
    chk("tx_idle", uart_tx, 1'b1);
  endtask

  initial begin
    int n, n0, na, bad, len, t;
    logic [31:0] v;

    // Reset and idle line
    reset = 1'b1;
    repeat (3) @(negedge hash_clk);
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge hash_clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_100", bad, 0);
    chk("idle_bytes", bytes_q.size(), 0);

    // Single nonce with busy timing around the final stop bit
    clear_q();
    strobe(32'hffbd9207, n);
    release_v();
    model_push(32'hffbd9207);
    chk("busy_rise", busy, 1'b1);
    wait_until(n + 2 + NONCE_CYC - 1);
    chk("busy_last_stop", busy, 1'b1);
    wait_until(n + 2 + NONCE_CYC + 1);
    chk("busy_fall", busy, 1'b0);
    check_stream(n + 2);

    // Directed burst 1..4 on consecutive cycles
    clear_q();
    for (int i = 1; i <= 4; i++) begin
      strobe(32'(i), n);
      if (i == 1) n0 = n;
      model_push(32'(i));
    end
    release_v();
    check_stream(n0 + 2);
    chk("burst_overflow", overflow, 1'b0);

    // Randomized bursts
    for (int r = 0; r < 6; r++) begin
      clear_q();
      repeat ($urandom_range(0, 20)) @(negedge hash_clk);
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        v = $urandom;
        strobe(v, n);
        if (i == 0) n0 = n;
        model_push(v);
      end
      release_v();
      check_stream(n0 + 2);
      chk($sformatf("rand%0d_overflow", r), overflow, 1'b0);
    end

    // Full FIFO with a write coincident with the LOAD pop
    clear_q();
    v = $urandom;
    strobe(v, na);
    release_v();
    model_push(v);
    wait_until(na + 2 + 30);
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      strobe(v, n);
      model_push(v);
    end
    release_v();
    wait_until(na + 2 + NONCE_CYC);
    v = $urandom;
    strobe(v, n);
    release_v();
    model_push(v);
    check_stream(na + 2);
    chk("fullpop_overflow", overflow, 1'b0);

    // Overflow: six strobes while a frame is active
    clear_q();
    v = $urandom;
    strobe(v, na);
    release_v();
    model_push(v);
    wait_until(na + 2 + 30);
    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      strobe(v, n);
      if (i < 4) model_push(v);
      if (i == 4) chk("ovf_before_drop", overflow, 1'b0);
      if (i == 5) chk("ovf_after_drop", overflow, 1'b1);
    end
    release_v();
    check_stream(na + 2);
    chk("ovf_sticky", overflow, 1'b1);
    reset = 1'b1;
    @(negedge hash_clk);
    @(negedge hash_clk);
    chk("ovf_cleared", overflow, 1'b0);
    reset = 1'b0;

    // Reset during DATA of byte 2, then a clean frame
    clear_q();
    strobe(32'h12345678, n);
    release_v();
    t = n + 2;
    wait_until(t + 2 * FRAME + 3 * DIV + 3);
    chk("mid_tx_low_data", busy, 1'b1);
    reset = 1'b1;
    @(negedge hash_clk);
    chk("mid_rst_tx", uart_tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge hash_clk);
    reset = 1'b0;
    clear_q();
    strobe(32'hdeadbeef, n);
    release_v();
    model_push(32'hdeadbeef);
    check_stream(n + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
